fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch front end.
// Issues one bus request at a time, places returned words into the decode
// register (d_valid/d_pc/d_instr) and keeps a one-entry skid buffer for a word
// that returns while decode is stalled. Taken branches/jumps are sampled when
// decode consumes them; the delay slot is always fetched before the target.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ireq_valid, ireq_addr      instruction-bus request (held until addr_ok)
//   iresp_addr_ok              bus accepted the request this cycle
//   iresp_data_ok, iresp_data  bus returns the instruction word this cycle
//   stall                      decode cannot consume
//   redirect_valid/_pc         taken branch/jump target from decode
//   d_valid, d_pc, d_instr     decode-stage register
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr
);

  localparam logic [31:0] RESET_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        pending;
  logic [31:0] pending_target;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;

  logic        consume;
  logic        take_redirect;
  logic        fetch_done;
  logic [31:0] redirect_aligned;
  logic [31:0] next_seq_pc;

  assign consume          = d_valid && !stall;
  assign take_redirect    = consume && redirect_valid;
  assign fetch_done       = ((state == S_REQ) && iresp_addr_ok && iresp_data_ok) ||
                            ((state == S_WAIT) && iresp_data_ok);
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign next_seq_pc      = pending ? pending_target : fetch_pc + 32'd4;

  // Request valid is decoded from state; gating with reset keeps it low during
  // the reset cycle while still being high on the first cycle after release.
  assign ireq_valid = (state == S_REQ) && !reset;
  assign ireq_addr  = {fetch_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_REQ;
      fetch_pc       <= RESET_ALIGNED;
      pending        <= 1'b0;
      pending_target <= '0;
      skid_pc        <= '0;
      skid_instr     <= '0;
      d_valid        <= 1'b0;
      d_pc           <= '0;
      d_instr        <= '0;
    end else begin
      if (fetch_done) begin
        if (!d_valid || consume) begin
          d_valid <= 1'b1;
          d_pc    <= ireq_addr;
          d_instr <= iresp_data;
          state   <= S_REQ;
        end else begin
          skid_pc    <= ireq_addr;
          skid_instr <= iresp_data;
          state      <= S_HOLD;
        end
        // A redirect taken on this very edge means the word just fetched is
        // the delay slot, so the target is the next fetch address directly.
        pending  <= 1'b0;
        fetch_pc <= take_redirect ? redirect_aligned : next_seq_pc;
      end else if ((state == S_HOLD) && consume) begin
        d_valid <= 1'b1;
        d_pc    <= skid_pc;
        d_instr <= skid_instr;
        state   <= S_REQ;
        // Delay slot was sitting in the skid buffer; fetch_pc had already
        // stepped past it and must be replaced by the target.
        if (take_redirect) begin
          fetch_pc <= redirect_aligned;
        end
      end else begin
        if (consume) begin
          d_valid <= 1'b0;
        end
        // Delay slot not fetched yet: remember the target for the advance
        // that follows its completion.
        if (take_redirect) begin
          pending        <= 1'b1;
          pending_target <= redirect_aligned;
        end
        if ((state == S_REQ) && iresp_addr_ok) begin
          state <= S_WAIT;
        end
      end
    end
  end

  // A branch cannot sit in a delay slot, so no redirect may arrive while one
  // is still pending.
  always_ff @(posedge clk) begin
    if (!reset && take_redirect) begin
      assert (!pending);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_valid        (d_valid),
    .d_pc           (d_pc),
    .d_instr        (d_instr)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Stimulus knobs (percent probabilities).
  int unsigned p_stall, p_addr, p_same, p_data, p_br;
  bit          tgt_hi;

  // Reference model: program-order stream of instruction addresses.
  // prog[i] is the i-th instruction the machine must fetch and deliver.
  logic [31:0] prog[$];
  bit          ds[int];   // indices that are delay slots
  int          issued, completed, consumed;
  bit          outst;
  logic [31:0] out_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h3c5a_96e1;
  endfunction

  function automatic bit rnd(input int unsigned p);
    return $urandom_range(99) < p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pc_at(input int i, output logic [31:0] pc);
    while (prog.size() <= i) prog.push_back(prog[prog.size()-1] + 32'd4);
    pc = prog[i];
  endtask

  task automatic model_reset();
    prog.delete();
    prog.push_back(RST_PC);
    ds.delete();
    issued    = 0;
    completed = 0;
    consumed  = 0;
    outst     = 0;
  endtask

  // Called at a negedge: check current outputs, drive inputs, update model,
  // advance one clock.
  task automatic step();
    int          buffered;
    logic        exp_iv, exp_dv, cons, acc;
    logic [31:0] pc, tgt, slot;
    buffered = completed - consumed;
    exp_iv   = !outst && (buffered < 2);
    exp_dv   = buffered >= 1;
    chk("ireq_valid", 32'(ireq_valid), 32'(exp_iv));
    if (exp_iv) begin
      pc_at(issued, pc);
      chk("ireq_addr", ireq_addr, pc);
    end
    chk("d_valid", 32'(d_valid), 32'(exp_dv));
    if (exp_dv) begin
      pc_at(consumed, pc);
      chk("d_pc", d_pc, pc);
      chk("d_instr", d_instr, mem(pc));
    end

    stall         = rnd(p_stall);
    cons          = exp_dv && !stall;
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = $urandom;
    acc           = 1'b0;
    if (exp_iv) begin
      acc           = rnd(p_addr);
      iresp_addr_ok = acc;
      if (acc && rnd(p_same)) begin
        pc_at(issued, pc);
        iresp_data_ok = 1'b1;
        iresp_data    = mem(pc);
      end
    end else if (outst && rnd(p_data)) begin
      iresp_data_ok = 1'b1;
      iresp_data    = mem(out_addr);
    end

    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (cons && !ds.exists(consumed) && rnd(p_br)) begin
      tgt = tgt_hi ? 32'hffff_ffe0 + 32'($urandom_range(31))
                   : RST_PC + 32'($urandom_range(255) << 2) + 32'($urandom_range(3));
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      pc_at(consumed + 1, slot);
      while (prog.size() > consumed + 2) void'(prog.pop_back());
      prog.push_back(tgt & ~32'd3);
      ds[consumed + 1] = 1'b1;
    end else if (!cons) begin
      redirect_valid = rnd(30);
    end

    if (acc) begin
      pc_at(issued, out_addr);
      issued++;
      if (iresp_data_ok) completed++;
      else outst = 1'b1;
    end else if (iresp_data_ok) begin
      completed++;
      outst = 1'b0;
    end
    if (cons) consumed++;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_ireq_valid", 32'(ireq_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_pc", d_pc, 32'd0);
    chk("rst_d_instr", d_instr, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_ireq_valid", 32'(ireq_valid), 32'd1);
    chk("first_ireq_addr", ireq_addr, RST_PC);
    model_reset();
  endtask

  task automatic set_knobs(input int unsigned st, input int unsigned ad, input int unsigned sm,
                           input int unsigned dt, input int unsigned br);
    p_stall = st;
    p_addr  = ad;
    p_same  = sm;
    p_data  = dt;
    p_br    = br;
  endtask

  initial begin
    tgt_hi = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    do_reset(2);

    // Zero-latency bus, no stall: back-to-back sequential delivery.
    set_knobs(0, 100, 100, 100, 0);
    repeat (6) step();

    // Zero-latency with branches taken.
    set_knobs(0, 100, 100, 100, 40);
    repeat (40) step();

    // Address phase held off for several cycles after reset.
    do_reset(1);
    set_knobs(0, 0, 0, 0, 0);
    repeat (3) step();
    set_knobs(0, 100, 50, 100, 0);
    repeat (10) step();

    // Long decode stall: skid buffer fills, requests stop, then drain.
    set_knobs(100, 100, 100, 100, 0);
    repeat (5) step();
    set_knobs(0, 100, 100, 100, 30);
    repeat (10) step();

    // Random mix of latencies, stalls and redirects.
    set_knobs(40, 60, 40, 50, 25);
    repeat (3000) step();

    // Targets near the top of the address space to exercise wrap-around.
    tgt_hi = 1'b1;
    set_knobs(30, 70, 50, 60, 30);
    repeat (400) step();
    tgt_hi = 1'b0;

    // Reset while a request is in the data phase with decode full.
    do_reset(1);
    set_knobs(100, 100, 100, 100, 0);
    step();
    set_knobs(100, 100, 0, 0, 0);
    step();
    step();
    do_reset(1);
    set_knobs(20, 80, 50, 70, 20);
    repeat (200) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
